// File: rtl/pokey_pkg.sv
// Shared definitions for the POKEY register bus: register addresses and the
// arbiter state encoding.
package pokey_pkg;

    localparam logic [3:0] AUDF1  = 4'h0;
    localparam logic [3:0] AUDC1  = 4'h1;
    localparam logic [3:0] AUDF2  = 4'h2;
    localparam logic [3:0] AUDC2  = 4'h3;
    localparam logic [3:0] AUDF3  = 4'h4;
    localparam logic [3:0] AUDC3  = 4'h5;
    localparam logic [3:0] AUDF4  = 4'h6;
    localparam logic [3:0] AUDC4  = 4'h7;
    localparam logic [3:0] AUDCTL = 4'h8;
    localparam logic [3:0] STIMER = 4'h9;
    localparam logic [3:0] SKRES  = 4'hA;
    localparam logic [3:0] POTGO  = 4'hB;
    localparam logic [3:0] SEROUT = 4'hD;
    localparam logic [3:0] IRQEN  = 4'hE;
    localparam logic [3:0] SKCTL  = 4'hF;

    // Read-side aliases of shared addresses.
    localparam logic [3:0] RANDOM = 4'hA;
    localparam logic [3:0] SKSTAT = 4'hF;

    localparam int FIFO_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_XFER = 2'd1,
        ST_SEQ_XFER = 2'd2,
        ST_CPU_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/pokey_wr_fifo.sv
// Sequencer write FIFO: {address, data} entries, head readable without latency
// so the arbiter can register it on the grant cycle.
module pokey_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                level_reg <= level_reg + LW'(1);
            end else if (do_pop && !do_push) begin
                level_reg <= level_reg - LW'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/pokey_bus_arb.sv
// Shares the POKEY register port between CPU accesses and buffered sequencer
// writes, with a bound on how long the CPU may starve the sequencer.
module pokey_bus_arb
    import pokey_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       cpu_adr_i,
    input  logic [7:0]       cpu_dat_i,
    input  logic             cpu_we_i,
    input  logic             cpu_stb_i,
    output logic             cpu_ack_o,
    output logic [7:0]       cpu_dat_o,
    input  logic [3:0]       seq_adr_i,
    input  logic [7:0]       seq_dat_i,
    input  logic             seq_valid_i,
    output logic             seq_ready_o,
    output logic [3:0]       pk_adr_o,
    output logic [7:0]       pk_dat_o,
    output logic             pk_we_o,
    output logic             pk_stb_o,
    input  logic             pk_ack_i,
    input  logic [7:0]       pk_dat_i,
    output logic [LVL_W-1:0] fifo_level_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  starve_reg, starve_next;
    logic [3:0]        adr_reg, adr_next;
    logic [7:0]        dat_reg, dat_next;
    logic              we_reg, we_next;
    logic              stb_reg, stb_next;
    logic              ack_reg, ack_next;
    logic [7:0]        rdat_reg, rdat_next;
    logic              cpu_grant, seq_grant;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;

    pokey_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (seq_valid_i),
        .pop   (fifo_pop),
        .wdata ({seq_adr_i, seq_dat_i}),
        .rdata (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        adr_next    = adr_reg;
        dat_next    = dat_reg;
        we_next     = we_reg;
        stb_next    = stb_reg;
        ack_next    = 1'b0;
        rdat_next   = rdat_reg;
        cpu_grant   = 1'b0;
        seq_grant   = 1'b0;
        fifo_pop    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_stb_i && (fifo_empty || starve_reg < CNT_W'(STARVE_MAX))) begin
                    cpu_grant  = 1'b1;
                    state_next = ST_CPU_XFER;
                    stb_next   = 1'b1;
                    adr_next   = cpu_adr_i;
                    dat_next   = cpu_dat_i;
                    we_next    = cpu_we_i;
                end else if (!fifo_empty) begin
                    seq_grant  = 1'b1;
                    state_next = ST_SEQ_XFER;
                    stb_next   = 1'b1;
                    adr_next   = fifo_head[11:8];
                    dat_next   = fifo_head[7:0];
                    we_next    = 1'b1;
                end
            end
            ST_CPU_XFER: begin
                if (pk_ack_i) begin
                    rdat_next  = pk_dat_i;
                    stb_next   = 1'b0;
                    ack_next   = 1'b1;
                    state_next = ST_CPU_DONE;
                end
            end
            ST_SEQ_XFER: begin
                if (pk_ack_i) begin
                    fifo_pop   = 1'b1;
                    stb_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            // One dead cycle so a CPU that drops its strobe on ack is not re-granted.
            ST_CPU_DONE: state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase

        if (fifo_empty || seq_grant) begin
            starve_next = '0;
        end else if (cpu_grant && starve_reg < CNT_W'(STARVE_MAX)) begin
            starve_next = starve_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;
            starve_reg <= '0;
            adr_reg    <= '0;
            dat_reg    <= '0;
            we_reg     <= 1'b0;
            stb_reg    <= 1'b0;
            ack_reg    <= 1'b0;
            rdat_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
            adr_reg    <= adr_next;
            dat_reg    <= dat_next;
            we_reg     <= we_next;
            stb_reg    <= stb_next;
            ack_reg    <= ack_next;
            rdat_reg   <= rdat_next;
        end
    end

    assign pk_adr_o     = adr_reg;
    assign pk_dat_o     = dat_reg;
    assign pk_we_o      = we_reg;
    assign pk_stb_o     = stb_reg;
    assign cpu_ack_o    = ack_reg;
    assign cpu_dat_o    = rdat_reg;
    assign fifo_level_o = fifo_level;
    assign seq_ready_o  = rst_ni && !fifo_full;

endmodule

// File: tb/tb_pokey_bus_arb.sv
// Bench for pokey_bus_arb: table-driven CPU transfers, hand-written FIFO,
// starvation and reset sequences, then randomized traffic against a queue model.
module tb_pokey_bus_arb;
    import pokey_pkg::*;

    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] cpu_adr_i;
    logic [7:0] cpu_dat_i;
    logic       cpu_we_i;
    logic       cpu_stb_i;
    logic       cpu_ack_o;
    logic [7:0] cpu_dat_o;
    logic [3:0] seq_adr_i;
    logic [7:0] seq_dat_i;
    logic       seq_valid_i;
    logic       seq_ready_o;
    logic [3:0] pk_adr_o;
    logic [7:0] pk_dat_o;
    logic       pk_we_o;
    logic       pk_stb_o;
    logic       pk_ack_i;
    logic [7:0] pk_dat_i;
    logic [2:0] fifo_level_o;

    pokey_bus_arb #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i), .cpu_we_i(cpu_we_i),
        .cpu_stb_i(cpu_stb_i), .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o),
        .seq_adr_i(seq_adr_i), .seq_dat_i(seq_dat_i), .seq_valid_i(seq_valid_i),
        .seq_ready_o(seq_ready_o),
        .pk_adr_o(pk_adr_o), .pk_dat_o(pk_dat_o), .pk_we_o(pk_we_o),
        .pk_stb_o(pk_stb_o), .pk_ack_i(pk_ack_i), .pk_dat_i(pk_dat_i),
        .fifo_level_o(fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    // POKEY model: ack after ack_delay wait cycles, read data from a table value or address function.
    int         ack_delay = 0;
    int         stb_cnt = 0;
    bit         use_fn = 1'b0;
    logic [7:0] rdata_val = 8'h00;
    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;

    function automatic logic [7:0] pk_rd(input logic [3:0] a);
        return {a ^ 4'h6, ~a};
    endfunction

    assign pk_ack_i = pk_stb_o && (stb_cnt >= ack_delay);
    assign pk_dat_i = use_fn ? pk_rd(pk_adr_o) : rdata_val;

    always @(posedge clk_i) begin
        stb_cnt <= (pk_stb_o && !pk_ack_i) ? stb_cnt + 1 : 0;
        cyc     <= cyc + 1;
    end

    typedef struct {
        int         cyc;
        logic       we;
        logic [3:0] adr;
        logic [7:0] dat;
    } acc_t;
    acc_t acc_q[$];

    always @(negedge clk_i) begin
        if (rst_ni && pk_stb_o && pk_ack_i) acc_q.push_back('{cyc, pk_we_o, pk_adr_o, pk_dat_o});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic seq_push(input logic [3:0] a, input logic [7:0] d);
        int w = 0;
        while (!seq_ready_o && w < 50) begin
            tick();
            w++;
        end
        chk("push_ready_wait", 32'(w < 50), 32'd1);
        seq_adr_i   = a;
        seq_dat_i   = d;
        seq_valid_i = 1'b1;
        tick();
        seq_valid_i = 1'b0;
    endtask

    // One CPU transfer; also watches two cycles past the ack for a repeated access.
    task automatic cpu_txn(input logic [3:0] a, input logic [7:0] d, input logic w,
                           output int stb_cycles, output int ack_edge, output int ack_cnt,
                           output logic [7:0] rd, output logic stable);
        stb_cycles = 0; ack_edge = -1; ack_cnt = 0; rd = 8'h00; stable = 1'b1;
        cpu_adr_i = a; cpu_dat_i = d; cpu_we_i = w; cpu_stb_i = 1'b1;
        for (int e = 1; e <= 40 && ack_edge < 0; e++) begin
            tick();
            if (pk_stb_o) begin
                stb_cycles++;
                if (pk_adr_o !== a || pk_we_o !== w || (w && pk_dat_o !== d)) stable = 1'b0;
            end
            if (cpu_ack_o) begin
                ack_edge = e; ack_cnt++; rd = cpu_dat_o; cpu_stb_i = 1'b0;
            end
        end
        cpu_stb_i = 1'b0;
        for (int e = 0; e < 2; e++) begin
            tick();
            if (pk_stb_o) stb_cycles++;
            if (cpu_ack_o) ack_cnt++;
        end
    endtask

    typedef struct {
        logic [3:0] adr;
        logic [7:0] dat;
        logic       we;
        int         dly;
        logic [7:0] rdv;
        int         exp_stb;
        int         exp_ack;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vt[6];

    // Random-phase state.
    logic [11:0] mq[$];
    bit          push_pend, acc_pend, cpu_busy;
    logic [11:0] push_val;
    logic [3:0]  pend_adr, req_adr;
    logic [7:0]  pend_dat, req_dat;
    logic        pend_we, req_we;
    int          cpu_wait, cpu_gap, cpu_run, n_cpu_txn, n_seq_txn;
    logic [11:0] head;

    initial begin
        int sc, ae, ac, base, w;
        logic [7:0] rd;
        logic st;
        logic [7:0] exp_dat[5];

        vt[0] = '{RANDOM, 8'h00, 1'b0, 0, 8'h5C, 1, 2, 8'h5C};
        vt[1] = '{STIMER, 8'h77, 1'b1, 3, 8'h00, 4, 5, 8'h00};
        vt[2] = '{SKSTAT, 8'h00, 1'b0, 1, 8'hA5, 2, 3, 8'hA5};
        vt[3] = '{AUDF1,  8'h10, 1'b1, 0, 8'h3C, 1, 2, 8'h3C};
        vt[4] = '{AUDCTL, 8'h00, 1'b0, 2, 8'h81, 3, 4, 8'h81};
        vt[5] = '{IRQEN,  8'hFF, 1'b1, 0, 8'h11, 1, 2, 8'h11};

        rst_ni = 1'b0; cpu_adr_i = '0; cpu_dat_i = '0; cpu_we_i = 1'b0; cpu_stb_i = 1'b0;
        seq_adr_i = '0; seq_dat_i = '0; seq_valid_i = 1'b0;
        tick(); tick();
        chk("rst_pk_stb", 32'(pk_stb_o), 32'd0);
        chk("rst_pk_we", 32'(pk_we_o), 32'd0);
        chk("rst_pk_adr_dat", 32'({pk_adr_o, pk_dat_o}), 32'd0);
        chk("rst_cpu_ack_dat", 32'({cpu_ack_o, cpu_dat_o}), 32'd0);
        chk("rst_level", 32'(fifo_level_o), 32'd0);
        chk("rst_ready_in_reset", 32'(seq_ready_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("rst_ready_after", 32'(seq_ready_o), 32'd1);

        // Table-driven CPU transfers.
        for (int i = 0; i < 6; i++) begin
            ack_delay = vt[i].dly;
            rdata_val = vt[i].rdv;
            cpu_txn(vt[i].adr, vt[i].dat, vt[i].we, sc, ae, ac, rd, st);
            chk($sformatf("vec%0d_stb_cycles", i), sc, vt[i].exp_stb);
            chk($sformatf("vec%0d_ack_edge", i), ae, vt[i].exp_ack);
            chk($sformatf("vec%0d_ack_count", i), ac, 1);
            chk($sformatf("vec%0d_cpu_dat", i), 32'(rd), 32'(vt[i].exp_rd));
            chk($sformatf("vec%0d_pk_stable", i), 32'(st), 32'd1);
            $display("vec %0d: adr=%0h we=%0b dly=%0d stb=%0d ack@%0d rd=%02h", i,
                     vt[i].adr, vt[i].we, vt[i].dly, sc, ae, rd);
        end
        ack_delay = 0;

        // Four back-to-back sequencer writes; first transfer stalled so the FIFO fills.
        ack_delay = 6;
        base = acc_q.size();
        seq_push(AUDF1, 8'h10); seq_push(AUDC1, 8'hA8);
        seq_push(AUDF2, 8'h20); seq_push(AUDC2, 8'hA4);
        chk("fill_level4", 32'(fifo_level_o), 32'd4);
        chk("fill_ready_low", 32'(seq_ready_o), 32'd0);
        ack_delay = 0;
        w = 0;
        while (fifo_level_o != 0 && w < 30) begin tick(); w++; end
        tick();
        chk("drain_level0", 32'(fifo_level_o), 32'd0);
        chk("drain_ready", 32'(seq_ready_o), 32'd1);
        chk("drain_count", acc_q.size() - base, 4);
        exp_dat[0] = 8'h10; exp_dat[1] = 8'hA8; exp_dat[2] = 8'h20; exp_dat[3] = 8'hA4;
        for (int i = 0; i < 4 && base + i < acc_q.size(); i++) begin
            chk($sformatf("drain%0d_write", i), 32'({acc_q[base+i].we, acc_q[base+i].adr, acc_q[base+i].dat}),
                32'({1'b1, 4'(i), exp_dat[i]}));
            if (i > 0) chk($sformatf("drain%0d_spacing", i), acc_q[base+i].cyc - acc_q[base+i-1].cyc, 2);
        end
        $display("seq fill/drain: %0d writes", acc_q.size() - base);

        // Starvation: CPU polls SKSTAT continuously with two sequencer writes queued.
        ack_delay = 10;
        cpu_adr_i = SKSTAT; cpu_we_i = 1'b0; cpu_stb_i = 1'b1;
        tick();
        base = acc_q.size();
        seq_push(AUDF3, 8'h31); seq_push(AUDC3, 8'h32);
        ack_delay = 0;
        w = 0;
        while (acc_q.size() - base < 9 && w < 80) begin tick(); w++; end
        cpu_stb_i = 1'b0;
        chk("starve_count", acc_q.size() - base, 9);
        for (int i = 0; i < 9 && base + i < acc_q.size(); i++) begin
            chk($sformatf("starve_grant%0d_we", i), 32'(acc_q[base+i].we), 32'((i == 4) || (i == 8)));
        end
        if (acc_q.size() - base >= 9) begin
            chk("starve_seq_a", 32'(acc_q[base+4].dat), 32'h31);
            chk("starve_seq_b", 32'(acc_q[base+8].dat), 32'h32);
        end
        tick(); tick(); tick();
        $display("starvation: %0d grants observed", acc_q.size() - base);

        // Full FIFO with a push offered in the pop cycle.
        ack_delay = 20;
        base = acc_q.size();
        for (int i = 0; i < 4; i++) seq_push(4'(i), 8'(8'h41 + i));
        seq_adr_i = 4'h4; seq_dat_i = 8'h45; seq_valid_i = 1'b1;
        tick(); tick();
        chk("full_hold_level", 32'(fifo_level_o), 32'd4);
        ack_delay = 0;
        tick();
        chk("full_pop_refuse", 32'(fifo_level_o), 32'd3);
        chk("full_pop_ready", 32'(seq_ready_o), 32'd1);
        tick();
        chk("full_push_next", 32'(fifo_level_o), 32'd4);
        seq_valid_i = 1'b0;
        w = 0;
        while (fifo_level_o != 0 && w < 30) begin tick(); w++; end
        tick();
        chk("full_drain_count", acc_q.size() - base, 5);
        for (int i = 0; i < 5 && base + i < acc_q.size(); i++) begin
            chk($sformatf("full_order%0d", i), 32'({acc_q[base+i].adr, acc_q[base+i].dat}),
                32'({4'(i), 8'(8'h41 + i)}));
        end
        $display("full/pop: %0d writes", acc_q.size() - base);

        // Reset during a stalled sequencer transfer.
        ack_delay = 50;
        seq_push(AUDCTL, 8'h66);
        tick();
        chk("rstx_stb_before", 32'(pk_stb_o), 32'd1);
        #3 rst_ni = 1'b0;
        #1;
        chk("rstx_stb_async", 32'(pk_stb_o), 32'd0);
        chk("rstx_ready_low", 32'(seq_ready_o), 32'd0);
        chk("rstx_level", 32'(fifo_level_o), 32'd0);
        chk("rstx_pk_regs", 32'({pk_we_o, pk_adr_o, pk_dat_o}), 32'd0);
        base = acc_q.size();
        tick(); tick();
        rst_ni = 1'b1;
        ack_delay = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("rstx_level_after", 32'(fifo_level_o), 32'd0);
        chk("rstx_ready_after", 32'(seq_ready_o), 32'd1);
        chk("rstx_idle", 32'(pk_stb_o), 32'd0);
        chk("rstx_no_access", acc_q.size() - base, 0);
        $display("reset mid-transfer: level=%0d ready=%0b", fifo_level_o, seq_ready_o);

        // Randomized traffic against a queue-level model.
        use_fn = 1'b1;
        mq.delete();
        push_pend = 0; acc_pend = 0; cpu_busy = 0; cpu_gap = 0; cpu_run = 0;
        n_cpu_txn = 0; n_seq_txn = 0;
        for (int c = 0; c < 3000; c++) begin
            if (push_pend) mq.push_back(push_val);
            if (acc_pend) begin
                if (cpu_ack_o) begin
                    n_cpu_txn++;
                    chk("rnd_cpu_access", 32'({pend_we, pend_adr, pend_we ? pend_dat : 8'h00}),
                        32'({req_we, req_adr, req_we ? req_dat : 8'h00}));
                    chk("rnd_cpu_rdata", 32'(cpu_dat_o), 32'(pk_rd(req_adr)));
                    if (mq.size() > 0) cpu_run++;
                    chk("rnd_starve_bound", 32'(cpu_run <= SMAX + 1), 32'd1);
                end else if (mq.size() == 0) begin
                    chk("rnd_unexpected_access", 32'({pend_we, pend_adr, pend_dat}), 32'h0);
                    n_err += (32'({pend_we, pend_adr, pend_dat}) == 0) ? 1 : 0;
                end else begin
                    n_seq_txn++;
                    head = mq.pop_front();
                    chk("rnd_seq_write", 32'({pend_we, pend_adr, pend_dat}), 32'({1'b1, head}));
                    cpu_run = 0;
                end
            end else begin
                chk("rnd_spurious_ack", 32'(cpu_ack_o), 32'd0);
            end
            if (mq.size() == 0) cpu_run = 0;
            chk("rnd_level", 32'(fifo_level_o), mq.size());
            chk("rnd_ready", 32'(seq_ready_o), 32'(mq.size() < DEPTH));

            if (cpu_ack_o && cpu_busy) begin
                cpu_stb_i = 1'b0; cpu_busy = 0; cpu_gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            end else if (!cpu_busy) begin
                if (cpu_gap > 0) cpu_gap--;
                else if (c < 2800) begin
                    req_adr = 4'($urandom_range(0, 15)); req_dat = 8'($urandom); req_we = 1'($urandom_range(0, 1));
                    cpu_adr_i = req_adr; cpu_dat_i = req_dat; cpu_we_i = req_we; cpu_stb_i = 1'b1;
                    cpu_busy = 1; cpu_wait = 0;
                end
            end else begin
                cpu_wait++;
                if (cpu_wait > 60) begin
                    chk("rnd_cpu_timeout", 32'(cpu_wait), 32'd60);
                    cpu_stb_i = 1'b0; cpu_busy = 0;
                end
            end
            if (push_pend) seq_valid_i = 1'b0;
            if (!seq_valid_i && c < 2800 && $urandom_range(0, 2) != 0) begin
                seq_valid_i = 1'b1; seq_adr_i = 4'($urandom_range(0, 15)); seq_dat_i = 8'($urandom);
            end
            if (!pk_stb_o) ack_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;

            push_pend = seq_valid_i && (mq.size() < DEPTH);
            push_val  = {seq_adr_i, seq_dat_i};
            acc_pend  = pk_stb_o && pk_ack_i;
            pend_adr  = pk_adr_o; pend_dat = pk_dat_o; pend_we = pk_we_o;
            tick();
        end
        seq_valid_i = 1'b0; cpu_stb_i = 1'b0;
        chk("rnd_final_model_empty", mq.size(), 0);
        chk("rnd_final_level", 32'(fifo_level_o), 32'd0);
        $display("random: %0d cpu transfers, %0d sequencer writes", n_cpu_txn, n_seq_txn);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
